// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline MEM stage with one outstanding data-memory access,
//             byte-lane store steering and sign/zero-extending load return.
// Revision  : 1.0
// ============================================================================
module mem_stage #(
  parameter int  WORD_SIZE = 32,
  parameter int  ADDR_SIZE = 32,
  parameter int  NUM_REGS  = 32,
  localparam int REG_SEL   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [WORD_SIZE-1:0] result,
  input  logic [WORD_SIZE-1:0] save_data,
  input  logic [REG_SEL-1:0]   rd,
  input  logic                 reg_write,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           data_size,
  input  logic                 data_sign,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_SIZE-1:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [WORD_SIZE-1:0] dmem_wdata,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 valid_out,
  output logic                 reg_write_out,
  output logic [REG_SEL-1:0]   rd_out,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 misalign_err,
  output logic [WORD_SIZE-1:0] mem_forward
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] dmem_addr_q, dmem_addr_d;
  logic                 dmem_we_q, dmem_we_d;
  logic [3:0]           dmem_be_q, dmem_be_d;
  logic [WORD_SIZE-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [REG_SEL-1:0]   rd_q, rd_d;
  logic                 reg_write_q, reg_write_d;
  logic                 load_q, load_d;
  logic [1:0]           size_q, size_d;
  logic                 sign_q, sign_d;
  logic [1:0]           lane_q, lane_d;
  logic                 valid_q, valid_d;
  logic                 rw_out_q, rw_out_d;
  logic [REG_SEL-1:0]   rd_out_q, rd_out_d;
  logic [WORD_SIZE-1:0] wb_q, wb_d;
  logic                 mis_q, mis_d;

  logic [ADDR_SIZE-1:0] ea;
  logic                 is_mem;
  logic                 misalign;
  logic [3:0]           st_be;
  logic [WORD_SIZE-1:0] st_wdata;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [WORD_SIZE-1:0] ld_data;

  assign ea       = ADDR_SIZE'(result);
  assign is_mem   = mem_read | mem_write;
  assign misalign = ((data_size == 2'b01) && ea[0]) ||
                    (data_size[1] && (ea[1:0] != 2'b00));

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = save_data;
    case (data_size)
      2'b00: begin
        st_be    = 4'b0001 << ea[1:0];
        st_wdata = {(WORD_SIZE/8){save_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {ea[1], 1'b0};
        st_wdata = {(WORD_SIZE/16){save_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = save_data;
      end
    endcase
  end

  // Load lane selection uses the byte offset captured at accept time.
  assign ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   ld_data = {{(WORD_SIZE-8){sign_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{(WORD_SIZE-16){sign_q & ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_we_d    = dmem_we_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    load_d       = load_q;
    size_d       = size_q;
    sign_d       = sign_q;
    lane_d       = lane_q;
    valid_d      = 1'b0;
    rw_out_d     = 1'b0;
    mis_d        = 1'b0;
    rd_out_d     = rd_out_q;
    wb_d         = wb_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!is_mem) begin
            valid_d  = 1'b1;
            wb_d     = result;
            rd_out_d = rd;
            rw_out_d = reg_write;
          end else if (misalign) begin
            valid_d  = 1'b1;
            mis_d    = 1'b1;
            rd_out_d = rd;
          end else begin
            state_d      = ACCESS;
            dmem_addr_d  = {ea[ADDR_SIZE-1:2], 2'b00};
            dmem_we_d    = mem_write;
            dmem_be_d    = st_be;
            dmem_wdata_d = st_wdata;
            rd_d         = rd;
            reg_write_d  = reg_write;
            load_d       = ~mem_write;
            size_d       = data_size;
            sign_d       = data_sign;
            lane_d       = ea[1:0];
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          rd_out_d = rd_q;
          rw_out_d = load_q & reg_write_q;
          if (load_q) wb_d = ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dmem_addr_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= 4'b0000;
      dmem_wdata_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      load_q       <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      lane_q       <= 2'b00;
      valid_q      <= 1'b0;
      rw_out_q     <= 1'b0;
      rd_out_q     <= '0;
      wb_q         <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_we_q    <= dmem_we_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      load_q       <= load_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      lane_q       <= lane_d;
      valid_q      <= valid_d;
      rw_out_q     <= rw_out_d;
      rd_out_q     <= rd_out_d;
      wb_q         <= wb_d;
      mis_q        <= mis_d;
    end
  end

  assign ready_in      = (state_q == IDLE);
  assign dmem_req      = (state_q == ACCESS);
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_be       = dmem_be_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign valid_out     = valid_q;
  assign reg_write_out = rw_out_q;
  assign rd_out        = rd_out_q;
  assign wb_data       = wb_q;
  assign misalign_err  = mis_q;
  assign mem_forward   = wb_q;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 WORD_SIZE SHALL be a parameter, default 32: data path width.
REQ-002 ADDR_SIZE SHALL be a parameter, default 32: data memory address width.
REQ-003 NUM_REGS SHALL be a parameter, default 32: register file depth; REG_SEL = $clog2(NUM_REGS).
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous, active-low.
REQ-006 valid_in  in  1: EX result valid; ready_in  out  1: stage can accept.
REQ-007 result  in  WORD_SIZE: ALU result or effective address; save_data  in  WORD_SIZE: store data.
REQ-008 rd  in  REG_SEL; reg_write, mem_read, mem_write  in  1 each: EX control.
REQ-009 data_size  in  2: 00 byte, 01 half, 10 word, 11 treated as word; data_sign  in  1: 1 = sign-extend loads.
REQ-010 dmem_req, dmem_we  out  1; dmem_addr  out  ADDR_SIZE (bits [1:0] = 0); dmem_be  out  4; dmem_wdata  out  WORD_SIZE.
REQ-011 dmem_rdata  in  WORD_SIZE; dmem_ack  in  1: memory completion.
REQ-012 valid_out, reg_write_out  out  1; rd_out  out  REG_SEL; wb_data  out  WORD_SIZE; misalign_err  out  1.
REQ-013 mem_forward  out  WORD_SIZE: equals wb_data, for the EX forwarding mux.

Function
REQ-014 A transfer SHALL occur on a rising edge where valid_in and ready_in are both 1; all inputs are captured into an internal EX/MEM register.
REQ-015 The FSM SHALL have states IDLE and ACCESS; ready_in = 1 only in IDLE.
REQ-016 On an accepted non-memory op (mem_read = mem_write = 0), the FSM SHALL stay in IDLE; in the next cycle valid_out = 1, wb_data = result, rd_out = rd, reg_write_out = reg_write. Latency is 1 cycle.
REQ-017 On an accepted aligned load or store, the FSM SHALL go to ACCESS.
REQ-018 In ACCESS, dmem_req SHALL be 1, and dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL be held stable until dmem_ack = 1 is sampled.
REQ-019 On the edge where dmem_ack = 1 is sampled in ACCESS, the FSM SHALL return to IDLE and present valid_out = 1 for one cycle.
REQ-020 Memory op latency SHALL be 1 + N cycles from accept, where N is the number of ACCESS cycles (N >= 1).
REQ-021 dmem_ack SHALL be ignored in IDLE; dmem_req SHALL never be asserted in IDLE.
REQ-022 Store byte lanes: byte: be = 0001 << addr[1:0], wdata = 4 copies of save_data[7:0]; half: be = 0011 << (2*addr[1]), wdata = 2 copies of save_data[15:0]; word: be = 1111, wdata = save_data.
REQ-023 Load extraction SHALL select the byte or half at addr[1:0] from dmem_rdata, then sign- or zero-extend per data_sign; word loads pass dmem_rdata unchanged.
REQ-024 Stores SHALL produce reg_write_out = 0; loads SHALL produce reg_write_out = captured reg_write.
REQ-025 Misalignment is a half access with addr[0] = 1, or a word access with addr[1:0] != 00. A misaligned memory op SHALL issue no dmem_req and SHALL stay in IDLE; the next cycle has valid_out = 1, misalign_err = 1, reg_write_out = 0.
REQ-026 When mem_read and mem_write are both 1, the op SHALL be treated as a store.
REQ-027 valid_out and misalign_err SHALL be single-cycle pulses; WB never backpressures.
REQ-028 wb_data, rd_out and mem_forward SHALL hold their last values while valid_out = 0.

Reset
REQ-029 When rst_n = 0, the following SHALL clear immediately, regardless of clk: FSM = IDLE; dmem_req, dmem_we, valid_out, reg_write_out, misalign_err = 0; dmem_be = 0000; wb_data, dmem_addr, dmem_wdata, rd_out = 0.
REQ-030 Reset during ACCESS SHALL abandon the access with no valid_out; a dmem_ack arriving after reset release SHALL be ignored.
REQ-031 ready_in SHALL be 1 in the first cycle after rst_n rises.

Verification
REQ-032 ALU op: result = 0x1234_5678, rd = 5, reg_write = 1 -> the next cycle has valid_out = 1, wb_data = 0x1234_5678, rd_out = 5, no dmem_req.
REQ-033 Signed byte load: addr = 0x103, dmem_rdata = 0x80FF_0000, ack after 3 cycles -> dmem_addr = 0x100, be = 1000; wb_data = 0xFFFF_FF80; ready_in = 0 for 3 cycles.
REQ-034 Unsigned half store: addr = 0x202, save_data = 0xAAAA_BEEF -> be = 1100, wdata = 0xBEEF_BEEF, we = 1; valid_out = 1 with reg_write_out = 0 on ack.
REQ-035 Misaligned word load: addr = 0x301 -> no dmem_req; the next cycle has misalign_err = 1, valid_out = 1, reg_write_out = 0.
REQ-036 Reset in ACCESS: assert rst_n = 0 mid-wait -> dmem_req falls without a clock edge; ack after release -> no valid_out.
REQ-037 Back-to-back: load (ack 1 cycle), then ALU op held on valid_in -> ALU accepted on the edge after the load ack; two valid_out pulses in order.
